// File: rtl/multi_gate_stim_checker_pkg.sv
// Shared types, constants and the golden gate function for the stimulus checker.
package multi_gate_tb_pkg;

  localparam int unsigned STIM_W = 24;
  localparam int unsigned A_LSB  = 0;
  localparam int unsigned O_LSB  = 8;
  localparam int unsigned N_BIT  = 23;

  // Galois mask for x^24+x^23+x^22+x^17+1 in right-shift form
  localparam logic [STIM_W-1:0] LFSR_TAPS = 24'hE10000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_FINISH
  } state_t;

  // Golden response of the gate block: &A & |O & ~N
  function automatic logic expected_y(input logic [STIM_W-1:0] word);
    return (&word[O_LSB-1:A_LSB]) & (|word[N_BIT-1:O_LSB]) & ~word[N_BIT];
  endfunction

endpackage

// File: rtl/multi_gate_stim_checker_lfsr.sv
// 24-bit Galois LFSR single step, purely combinational.
module mg_lfsr24
  import multi_gate_tb_pkg::*;
(
  input  logic [STIM_W-1:0] i_word,
  output logic [STIM_W-1:0] o_next
);

  // Shift right and fold the taps back in when the outgoing bit is set
  always_comb begin
    o_next = (i_word >> 1) ^ (i_word[0] ? LFSR_TAPS : '0);
  end

endmodule

// File: rtl/multi_gate_stim_checker.sv
// Stimulus driver / response checker for the multi-gate block: drives a word,
// waits SETTLE_CYCLES, samples Y and counts mismatches against &A & |O & ~N.
module multi_gate_stim_checker
  import multi_gate_tb_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ERR_CNT_W     = 16,
  parameter int unsigned IDX_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 mode,
  input  logic [STIM_W-1:0]    seed,
  input  logic [IDX_W-1:0]     num_vectors,
  output logic [7:0]           a_out,
  output logic [14:0]          o_out,
  output logic                 n_out,
  input  logic                 y_in,
  output logic                 busy,
  output logic                 done,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 first_err_vld,
  output logic [IDX_W-1:0]     first_err_idx
);

  state_t                r_state;
  state_t                w_next;
  logic                  r_mode;
  logic [IDX_W-1:0]      r_nv;
  logic [IDX_W-1:0]      r_idx;
  logic [STIM_W-1:0]     r_word;
  logic [STIM_W-1:0]     r_stim;
  logic                  r_exp;
  logic [3:0]            r_settle;
  logic                  r_busy;
  logic                  r_done;
  logic [ERR_CNT_W-1:0]  r_err;
  logic                  r_vld;
  logic [IDX_W-1:0]      r_fidx;

  logic                  w_accept;
  logic                  w_settle_last;
  logic [IDX_W:0]        w_idx_inc;
  logic                  w_more;
  logic                  w_mismatch;
  logic                  w_check_go;
  logic [STIM_W-1:0]     w_lfsr;

  mg_lfsr24 u_lfsr (
    .i_word (r_word),
    .o_next (w_lfsr)
  );

  assign w_accept      = (r_state == ST_IDLE) && start && !abort;
  assign w_settle_last = (r_settle == 4'(SETTLE_CYCLES - 1));
  // One extra bit keeps the compare correct when num_vectors is all-ones
  assign w_idx_inc     = {1'b0, r_idx} + (IDX_W+1)'(1);
  assign w_more        = w_idx_inc < {1'b0, r_nv};
  assign w_mismatch    = (y_in != r_exp);
  assign w_check_go    = (r_state == ST_CHECK) && !abort;

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = (num_vectors == '0) ? ST_FINISH : ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (abort)                   w_next = ST_IDLE;
        else if (SETTLE_CYCLES == 0) w_next = ST_CHECK;
        else                         w_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (abort)              w_next = ST_IDLE;
        else if (w_settle_last) w_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (abort)       w_next = ST_IDLE;
        else if (w_more) w_next = ST_DRIVE;
        else             w_next = ST_FINISH;
      end
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // State register plus registered busy/done status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == ST_DRIVE) || (w_next == ST_SETTLE) || (w_next == ST_CHECK);
      r_done  <= (w_next == ST_FINISH);
    end
  end

  // Settle counter runs only while in SETTLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle <= '0;
    end else if (r_state == ST_SETTLE) begin
      r_settle <= r_settle + 4'd1;
    end else begin
      r_settle <= '0;
    end
  end

  // Run configuration, vector index and stimulus word generator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= 1'b0;
      r_nv   <= '0;
      r_idx  <= '0;
      r_word <= '0;
    end else if (w_accept) begin
      r_mode <= mode;
      r_nv   <= num_vectors;
      r_idx  <= '0;
      r_word <= (mode && (seed == '0)) ? STIM_W'(1) : seed;
    end else if (w_check_go) begin
      r_idx  <= w_idx_inc[IDX_W-1:0];
      r_word <= r_mode ? w_lfsr : (r_word + STIM_W'(1));
    end
  end

  // Stimulus output register and golden value; cleared whenever the run stops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stim <= '0;
      r_exp  <= 1'b0;
    end else if ((r_state == ST_DRIVE) && !abort) begin
      r_stim <= r_word;
      r_exp  <= expected_y(r_word);
    end else if ((w_next == ST_IDLE) || (w_next == ST_FINISH)) begin
      r_stim <= '0;
    end
  end

  // Result registers: saturating mismatch count and first failing index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err  <= '0;
      r_vld  <= 1'b0;
      r_fidx <= '0;
    end else if (w_accept) begin
      r_err  <= '0;
      r_vld  <= 1'b0;
      r_fidx <= '0;
    end else if (w_check_go && w_mismatch) begin
      if (r_err != '1) begin
        r_err <= r_err + ERR_CNT_W'(1);
      end
      if (!r_vld) begin
        r_vld  <= 1'b1;
        r_fidx <= r_idx;
      end
    end
  end

  assign a_out         = r_stim[A_LSB +: 8];
  assign o_out         = r_stim[O_LSB +: 15];
  assign n_out         = r_stim[N_BIT];
  assign busy          = r_busy;
  assign done          = r_done;
  assign err_count     = r_err;
  assign first_err_vld = r_vld;
  assign first_err_idx = r_fidx;

endmodule

// File: tb/tb_multi_gate_stim_checker.sv
// Bench: checker driving a behavioural gate model, with a run table,
// a result scoreboard and a per-vector stimulus monitor.
module tb_multi_gate_stim_checker;
  import multi_gate_tb_pkg::*;

  localparam int unsigned S = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        rst_n, start, abort, mode;
  logic [23:0] seed;
  logic [15:0] num_vectors;
  logic [7:0]  a_out;
  logic [14:0] o_out;
  logic        n_out, y_in, busy, done, first_err_vld;
  logic [15:0] err_count, first_err_idx;
  logic [1:0]  yforce;   // 0: gate model, 1: force 0, 2: force 1

  // saturation instance
  logic        s_start, s_abort, s_mode;
  logic [23:0] s_seed;
  logic [7:0]  s_nv;
  logic [7:0]  s_a;
  logic [14:0] s_o;
  logic        s_n, s_y, s_busy, s_done, s_vld;
  logic [3:0]  s_err;
  logic [7:0]  s_idx;
  logic [1:0]  s_yforce;

  always_comb begin
    y_in = (yforce == 2'd0) ? (&a_out & |o_out & ~n_out) : (yforce == 2'd2);
    s_y  = (s_yforce == 2'd0) ? (&s_a & |s_o & ~s_n) : (s_yforce == 2'd2);
  end

  multi_gate_stim_checker #(.SETTLE_CYCLES(S), .ERR_CNT_W(16), .IDX_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .seed(seed), .num_vectors(num_vectors), .a_out(a_out), .o_out(o_out),
    .n_out(n_out), .y_in(y_in), .busy(busy), .done(done), .err_count(err_count),
    .first_err_vld(first_err_vld), .first_err_idx(first_err_idx)
  );

  multi_gate_stim_checker #(.SETTLE_CYCLES(0), .ERR_CNT_W(4), .IDX_W(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort), .mode(s_mode),
    .seed(s_seed), .num_vectors(s_nv), .a_out(s_a), .o_out(s_o),
    .n_out(s_n), .y_in(s_y), .busy(s_busy), .done(s_done), .err_count(s_err),
    .first_err_vld(s_vld), .first_err_idx(s_idx)
  );

  typedef struct {
    logic        m;
    logic [23:0] seed;
    logic [15:0] nv;
    logic [1:0]  yf;
  } run_t;

  typedef struct {
    logic [15:0] err;
    logic        vld;
    logic [15:0] idx;
    int unsigned lat;
  } res_t;

  int          total = 0;
  int          bad   = 0;
  res_t        q_res[$];
  logic [23:0] q_word[$];
  run_t        tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] model_step(input logic [23:0] w, input logic m);
    if (m) return {1'b0, w[23:1]} ^ (w[0] ? 24'hE10000 : 24'h0);
    return w + 24'd1;
  endfunction

  function automatic logic gold(input logic [23:0] w);
    return (&w[7:0]) & (|w[22:8]) & ~w[23];
  endfunction

  task automatic model_run(input run_t r, input int unsigned errmax, input int unsigned settle,
                           input bit push_words, output res_t res);
    logic [23:0] w;
    logic        y;
    w = (r.m && r.seed == 24'h0) ? 24'h000001 : r.seed;
    res.err = 0; res.vld = 0; res.idx = 0;
    for (int unsigned k = 0; k < r.nv; k++) begin
      if (push_words) q_word.push_back(w);
      y = (r.yf == 2'd0) ? gold(w) : (r.yf == 2'd2);
      if (y != gold(w)) begin
        if (32'(res.err) < errmax) res.err = res.err + 16'd1;
        if (!res.vld) begin res.vld = 1'b1; res.idx = 16'(k); end
      end
      w = model_step(w, r.m);
    end
    res.lat = (r.nv == 0) ? 0 : 32'(r.nv) * (settle + 2);
  endtask

  // Stimulus monitor: word k is on the outputs (S+2)*k+1 cycles after busy rises
  bit          prev_busy = 1'b0;
  int unsigned bcnt = 0;
  logic [23:0] mon_exp;
  always @(negedge clk) begin
    if (busy && !prev_busy) bcnt = 0;
    else if (busy) bcnt++;
    if (busy && (bcnt % (S + 2)) == 1 && q_word.size() > 0) begin
      mon_exp = q_word.pop_front();
      check("stim word", {n_out, o_out, a_out}, mon_exp);
    end
    prev_busy = busy;
  end

  task automatic do_run(input run_t r, input string tag);
    res_t        e, got_e;
    int unsigned k;
    bit          busy_ok;
    model_run(r, 32'hFFFF, S, 1'b1, e);
    q_res.push_back(e);
    @(negedge clk);
    mode = r.m; seed = r.seed; num_vectors = r.nv; yforce = r.yf; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0; busy_ok = 1'b1;
    @(negedge clk);
    while (!done && k < 1000) begin
      if (busy !== (r.nv != 0)) busy_ok = 1'b0;
      k++;
      @(negedge clk);
    end
    got_e = q_res.pop_front();
    check({tag, " done seen"}, done, 1);
    check({tag, " latency"}, k, got_e.lat);
    check({tag, " busy during run"}, busy_ok, 1);
    check({tag, " busy at done"}, busy, 0);
    check({tag, " stim zero at done"}, {n_out, o_out, a_out}, 0);
    check({tag, " err_count"}, err_count, got_e.err);
    check({tag, " first_err_vld"}, first_err_vld, got_e.vld);
    check({tag, " first_err_idx"}, first_err_idx, got_e.idx);
    @(negedge clk);
    check({tag, " done one cycle"}, done, 0);
    check({tag, " all words seen"}, q_word.size(), 0);
    q_word.delete();
  endtask

  initial begin
    res_t        se;
    run_t        sr;
    int unsigned k;
    bit          flag;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; seed = '0;
    num_vectors = '0; yforce = 2'd0;
    s_start = 1'b0; s_abort = 1'b0; s_mode = 1'b0; s_seed = '0; s_nv = '0; s_yforce = 2'd0;

    tbl[0] = '{m: 1'b0, seed: 24'h0000FF, nv: 16'd4,   yf: 2'd0};
    tbl[1] = '{m: 1'b0, seed: 24'h800000, nv: 16'd1,   yf: 2'd0};
    tbl[2] = '{m: 1'b1, seed: 24'h000001, nv: 16'd100, yf: 2'd2};
    tbl[3] = '{m: 1'b0, seed: 24'h000000, nv: 16'd0,   yf: 2'd0};
    tbl[4] = '{m: 1'b1, seed: 24'h000000, nv: 16'd20,  yf: 2'd1};
    tbl[5] = '{m: 1'b0, seed: 24'h7FFFFE, nv: 16'd3,   yf: 2'd1};
    tbl[6] = '{m: 1'b0, seed: 24'hFFFFFF, nv: 16'd2,   yf: 2'd2};

    // reset values
    repeat (2) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err_count", err_count, 0);
    check("rst first_err_vld", first_err_vld, 0);
    check("rst first_err_idx", first_err_idx, 0);
    check("rst stim", {n_out, o_out, a_out}, 0);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 7; i++) begin
      do_run(tbl[i], $sformatf("run%0d", i));
    end

    // abort in SETTLE of vector 1: vector 0 already mismatched (word 0, y forced 1)
    q_word.push_back(24'h000000);
    q_word.push_back(24'h000001);
    @(negedge clk);
    mode = 1'b0; seed = 24'h0; num_vectors = 16'd10; yforce = 2'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort stim", {n_out, o_out, a_out}, 0);
    check("abort err_count", err_count, 1);
    check("abort first_err_vld", first_err_vld, 1);
    check("abort first_err_idx", first_err_idx, 0);
    flag = 1'b0;
    repeat (30) begin @(negedge clk); if (done || busy) flag = 1'b1; end
    check("abort no done", flag, 0);
    check("abort words seen", q_word.size(), 0);
    q_word.delete();

    // start and abort together in IDLE: abort wins
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    flag = 1'b0;
    repeat (5) begin @(negedge clk); if (busy || done) flag = 1'b1; end
    check("start+abort ignored", flag, 0);
    check("start+abort results held", err_count, 1);

    // a fresh start after abort
    do_run(tbl[0], "after abort");

    // reset mid-run
    @(negedge clk);
    mode = 1'b0; seed = 24'h0000FF; num_vectors = 16'd10; yforce = 2'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst stim", {n_out, o_out, a_out}, 0);
    check("midrst err_count", err_count, 0);
    flag = 1'b0;
    repeat (3) begin @(negedge clk); if (done) flag = 1'b1; end
    check("midrst no done", flag, 0);
    rst_n = 1'b1;

    // saturation and all-ones length on the narrow instance; extra starts ignored
    sr = '{m: 1'b0, seed: 24'h000000, nv: 16'h00FF, yf: 2'd2};
    model_run(sr, 15, 0, 1'b0, se);
    @(negedge clk);
    s_mode = 1'b0; s_seed = 24'h0; s_nv = 8'hFF; s_yforce = 2'd2; s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    k = 0;
    @(negedge clk);
    while (!s_done && k < 2000) begin
      if (k == 100 || k == 300) s_start = 1'b1;
      else s_start = 1'b0;
      k++;
      @(negedge clk);
    end
    s_start = 1'b0;
    check("sat done seen", s_done, 1);
    check("sat latency", k, se.lat);
    check("sat err_count", s_err, se.err[3:0]);
    check("sat first_err_vld", s_vld, se.vld);
    check("sat first_err_idx", s_idx, se.idx[7:0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
